// File: rtl/uart_rx_framed.sv
// uart_rx_framed: 8N1 UART receiver with runtime bit period, false-start rejection and framing checks.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx_framed #(
  parameter int unsigned CLK_FREQ_HZ = 48_000_000
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [31:0] baudrate,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [7:0]  o_Rx_Byte,
  output logic        o_Rx_Active,
  output logic        o_Framing_Error
`ifdef UART_RX_PARITY_EN
  ,
  input  logic        i_Parity_Odd,
  output logic        o_Parity_Error
`endif
);

  // IDLE wait start | START mid-bit recheck | DATA 8 bits | PARITY | STOP | CLEANUP 1 cycle | WAIT_IDLE line low after error
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta, rx_sync;
  logic [31:0] cpb_calc;
  logic        cpb_legal;
  logic [15:0] cpb_q, cnt_q, cpb_half, cpb_last;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        cnt_clr, load_cpb, sample_data, sample_stop;
`ifdef UART_RX_PARITY_EN
  logic        sample_parity, parity_bit_q, parity_ok;
  assign parity_ok = (parity_bit_q == ((^shift_q) ^ i_Parity_Odd));
`endif

  assign cpb_calc  = (baudrate == 32'd0) ? 32'd0 : (32'(CLK_FREQ_HZ) / baudrate);
  assign cpb_legal = (baudrate != 32'd0) && (cpb_calc >= 32'd4) && (cpb_calc <= 32'd65535);
  assign cpb_half  = (cpb_q - 16'd1) >> 1;
  assign cpb_last  = cpb_q - 16'd1;

  assign o_Rx_Active = (state_q == DATA) || (state_q == STOP)
`ifdef UART_RX_PARITY_EN
                       || (state_q == PARITY)
`endif
                       ;

  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    load_cpb    = 1'b0;
    sample_data = 1'b0;
    sample_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_parity = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_sync && cpb_legal) begin
          state_d  = START;
          load_cpb = 1'b1;
        end
      end
      START: begin
        if (cnt_q == cpb_half) state_d = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == cpb_last) begin
          sample_data = 1'b1;
          cnt_clr     = 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == cpb_last) begin
          sample_parity = 1'b1;
          state_d       = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == cpb_last) begin
          sample_stop = 1'b1;
          state_d     = rx_sync ? CLEANUP : WAIT_IDLE;
        end
      end
      CLEANUP:   state_d = IDLE;
      WAIT_IDLE: if (rx_sync) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_clr = 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      rx_meta         <= 1'b1;
      rx_sync         <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= 16'd0;
      cpb_q           <= 16'd0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'd0;
      o_Rx_DV         <= 1'b0;
      o_Rx_Byte       <= 8'd0;
      o_Framing_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q    <= 1'b0;
      o_Parity_Error  <= 1'b0;
`endif
    end else begin
      rx_meta         <= i_Rx_Serial;
      rx_sync         <= rx_meta;
      state_q         <= state_d;
      cnt_q           <= cnt_clr ? 16'd0 : cnt_q + 16'd1;
      o_Rx_DV         <= 1'b0;
      o_Framing_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Error  <= 1'b0;
      if (sample_parity) parity_bit_q <= rx_sync;
`endif
      if (load_cpb) begin
        cpb_q     <= cpb_calc[15:0];
        bit_idx_q <= 3'd0;
      end
      if (sample_data) begin
        shift_q   <= {rx_sync, shift_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      // Framing error outranks parity error; byte only loads on a fully clean frame.
      if (sample_stop) begin
        if (!rx_sync) o_Framing_Error <= 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (!parity_ok) o_Parity_Error <= 1'b1;
`endif
        else begin
          o_Rx_DV   <= 1'b1;
          o_Rx_Byte <= shift_q;
        end
      end
    end
  end

endmodule
